// File: rtl/regfile_seq.sv
// Sequencer that shares one single-port register-file RAM between two operand
// reads and the writeback. Both operands return together as one registered bundle.
module regfile_seq #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter bit WB_PRIORITY = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              op_valid,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              busy,
   output logic              ram_ce,
   output logic              ram_oce,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              ram_reset
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD1  = 3'd1,
      S_RD2  = 3'd2,
      S_CAP  = 3'd3,
      S_DONE = 3'd4,
      S_WB   = 3'd5
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_rs1_q;
   logic [ADDR_W-1:0]   r_rs2_q;
   logic                r_op_valid;
   logic [DATA_W-1:0]   r_rs1_data;
   logic [DATA_W-1:0]   r_rs2_data;
   logic                r_ram_ce;
   logic                r_ram_wre;
   logic [ADDR_W-1:0]   r_ram_ad;
   logic [DATA_W-1:0]   r_ram_din;

   logic                w_idle;
   logic                w_rd_hs;
   logic                w_wb_hs;

   // Arbitration happens only in IDLE; the losing side sees ready low that cycle.
   assign w_idle       = (r_state == S_IDLE) && !reset;
   assign rd_req_ready = w_idle && !(wb_valid && WB_PRIORITY);
   assign wb_ready     = w_idle && !(rd_req_valid && !WB_PRIORITY);
   assign w_rd_hs      = rd_req_valid && rd_req_ready;
   assign w_wb_hs      = wb_valid && wb_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rs1_q    <= '0;
         r_rs2_q    <= '0;
         r_op_valid <= 1'b0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_ram_ce   <= 1'b0;
         r_ram_wre  <= 1'b0;
         r_ram_ad   <= '0;
         r_ram_din  <= '0;
      end else begin
         r_op_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rd_hs) begin
                  r_rs1_q   <= rs1_addr;
                  r_rs2_q   <= rs2_addr;
                  r_ram_ad  <= rs1_addr;
                  r_ram_ce  <= 1'b1;
                  r_ram_wre <= 1'b0;
                  r_state   <= S_RD1;
               end else if (w_wb_hs && (wb_addr != '0)) begin
                  // Writes to x0 are accepted but dropped without touching the RAM.
                  r_ram_ad  <= wb_addr;
                  r_ram_din <= wb_data;
                  r_ram_ce  <= 1'b1;
                  r_ram_wre <= 1'b1;
                  r_state   <= S_WB;
               end
            end
            S_RD1: begin
               r_ram_ad <= r_rs2_q;
               r_state  <= S_RD2;
            end
            S_RD2: begin
               r_rs1_data <= (r_rs1_q == '0) ? '0 : ram_dout;
               r_ram_ce   <= 1'b0;
               r_state    <= S_CAP;
            end
            S_CAP: begin
               r_rs2_data <= (r_rs2_q == '0) ? '0 : ram_dout;
               r_op_valid <= 1'b1;
               r_state    <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            S_WB: begin
               r_ram_ce  <= 1'b0;
               r_ram_wre <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_ram_ce  <= 1'b0;
               r_ram_wre <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign op_valid  = r_op_valid;
   assign rs1_data  = r_rs1_data;
   assign rs2_data  = r_rs2_data;
   assign busy      = (r_state != S_IDLE);
   assign ram_ce    = r_ram_ce;
   assign ram_oce   = 1'b1;
   assign ram_wre   = r_ram_wre;
   assign ram_ad    = r_ram_ad;
   assign ram_din   = r_ram_din;
   assign ram_reset = reset;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq: instance 0 uses writeback priority, instance 1 read
// priority, each with its own behavioural single-port RAM.
module tb_regfile_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        rd_req_valid [2];
   logic        rd_req_ready [2];
   logic        op_valid     [2];
   logic        wb_valid     [2];
   logic        wb_ready     [2];
   logic        busy         [2];
   logic        ram_ce       [2];
   logic        ram_oce      [2];
   logic        ram_wre      [2];
   logic        ram_reset    [2];
   logic [4:0]  rs1_addr     [2];
   logic [4:0]  rs2_addr     [2];
   logic [4:0]  wb_addr      [2];
   logic [4:0]  ram_ad       [2];
   logic [31:0] rs1_data     [2];
   logic [31:0] rs2_data     [2];
   logic [31:0] wb_data      [2];
   logic [31:0] ram_din      [2];
   logic [31:0] ram_dout     [2];

   int checks = 0;
   int passed = 0;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         logic [31:0] mem [32];
         logic [31:0] written = '0;
         logic [31:0] dout_reg;

         regfile_seq #(
            .DATA_W(32), .ADDR_W(5), .WB_PRIORITY(gi == 0)
         ) u_dut (
            .clk(clk), .reset(reset),
            .rd_req_valid(rd_req_valid[gi]), .rd_req_ready(rd_req_ready[gi]),
            .rs1_addr(rs1_addr[gi]), .rs2_addr(rs2_addr[gi]),
            .op_valid(op_valid[gi]), .rs1_data(rs1_data[gi]), .rs2_data(rs2_data[gi]),
            .wb_valid(wb_valid[gi]), .wb_ready(wb_ready[gi]),
            .wb_addr(wb_addr[gi]), .wb_data(wb_data[gi]),
            .busy(busy[gi]), .ram_ce(ram_ce[gi]), .ram_oce(ram_oce[gi]),
            .ram_wre(ram_wre[gi]), .ram_ad(ram_ad[gi]), .ram_din(ram_din[gi]),
            .ram_dout(ram_dout[gi]), .ram_reset(ram_reset[gi])
         );

         // Never-written locations return garbage, so x0 forcing is visible.
         always @(posedge clk) begin
            if (ram_ce[gi]) begin
               if (ram_wre[gi]) begin
                  mem[ram_ad[gi]]     <= ram_din[gi];
                  written[ram_ad[gi]] <= 1'b1;
               end else begin
                  dout_reg <= written[ram_ad[gi]] ? mem[ram_ad[gi]] : 32'hBAAD_F00D;
               end
            end
         end
         assign ram_dout[gi] = dout_reg;
      end
   endgenerate

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int d, input logic [4:0] a, input logic [31:0] v,
                           output logic wre, output logic [4:0] ad, output logic bsy);
      int n;
      n = 0;
      wb_valid[d] = 1'b1; wb_addr[d] = a; wb_data[d] = v;
      #1;
      while (!wb_ready[d] && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (n >= 20) $display("FAIL wb_handshake: dut %0d addr %0d got no ready, required ready within 20 cycles", d, a);
      else passed++;
      @(posedge clk);
      #1;
      wb_valid[d] = 1'b0;
      wre = ram_wre[d]; ad = ram_ad[d]; bsy = busy[d];
   endtask

   task automatic do_read(input int d, input logic [4:0] a1, input logic [4:0] a2,
                          output int lat, output logic [31:0] d1, output logic [31:0] d2);
      int n;
      n = 0;
      rd_req_valid[d] = 1'b1; rs1_addr[d] = a1; rs2_addr[d] = a2;
      #1;
      while (!rd_req_ready[d] && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (n >= 20) $display("FAIL rd_handshake: dut %0d got no ready, required ready within 20 cycles", d);
      else passed++;
      @(posedge clk);
      #1;
      rd_req_valid[d] = 1'b0;
      lat = 1;
      while (!op_valid[d] && lat < 10) begin
         tick();
         lat++;
      end
      d1 = rs1_data[d]; d2 = rs2_data[d];
   endtask

   logic        w_wre;
   logic        w_bsy;
   logic [4:0]  w_ad;
   int          lat;
   logic [31:0] d1, d2;

   task automatic test_reset();
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         rd_req_valid[d] = 1'b0; wb_valid[d] = 1'b0;
         rs1_addr[d] = '0; rs2_addr[d] = '0; wb_addr[d] = '0; wb_data[d] = '0;
      end
      repeat (3) tick();
      checks++;
      if (rd_req_ready[0] !== 1'b0 || ram_reset[0] !== 1'b1)
         $display("FAIL reset_ready: got ready=%b ram_reset=%b, required 0/1", rd_req_ready[0], ram_reset[0]);
      else passed++;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({op_valid[d], busy[d], ram_ce[d], ram_wre[d], rd_req_ready[d], wb_ready[d], ram_oce[d]} !== 7'b0000111)
            $display("FAIL reset_ctrl: dut %0d got %b, required 0000111", d,
                     {op_valid[d], busy[d], ram_ce[d], ram_wre[d], rd_req_ready[d], wb_ready[d], ram_oce[d]});
         else passed++;
         checks++;
         if ({rs1_data[d], rs2_data[d], ram_din[d], ram_ad[d]} !== 101'd0)
            $display("FAIL reset_data: dut %0d got rs1=%h rs2=%h din=%h ad=%h, required all 0",
                     d, rs1_data[d], rs2_data[d], ram_din[d], ram_ad[d]);
         else passed++;
      end
      tick();
   endtask

   task automatic test_write_read();
      do_write(0, 5'd5, 32'hDEAD_BEEF, w_wre, w_ad, w_bsy);
      checks++;
      if (w_wre !== 1'b1 || w_ad !== 5'd5)
         $display("FAIL wb_cycle: got wre=%b ad=%0d, required wre=1 ad=5", w_wre, w_ad);
      else passed++;
      do_read(0, 5'd5, 5'd0, lat, d1, d2);
      checks++;
      if (lat !== 4) $display("FAIL rd_latency: got %0d, required 4", lat);
      else passed++;
      checks++;
      if (d1 !== 32'hDEAD_BEEF || d2 !== 32'h0)
         $display("FAIL rd_x5: got rs1=%h rs2=%h, required deadbeef/00000000", d1, d2);
      else passed++;
      tick();
      checks++;
      if (op_valid[0] !== 1'b0 || busy[0] !== 1'b0)
         $display("FAIL op_pulse: got op_valid=%b busy=%b after DONE, required 0/0", op_valid[0], busy[0]);
      else passed++;
   endtask

   task automatic test_x0();
      do_write(0, 5'd0, 32'h1234_5678, w_wre, w_ad, w_bsy);
      checks++;
      if (w_wre !== 1'b0 || w_bsy !== 1'b0)
         $display("FAIL x0_write: got wre=%b busy=%b, required 0/0", w_wre, w_bsy);
      else passed++;
      do_read(0, 5'd0, 5'd0, lat, d1, d2);
      checks++;
      if (lat !== 4 || d1 !== 32'h0 || d2 !== 32'h0)
         $display("FAIL x0_read: got lat=%0d rs1=%h rs2=%h, required 4/0/0", lat, d1, d2);
      else passed++;
      tick();
   endtask

   task automatic test_priority();
      int          wb_cyc [2];
      int          rd_cyc [2];
      logic [31:0] op1    [2];
      do_write(0, 5'd7, 32'h1111_1111, w_wre, w_ad, w_bsy);
      do_write(1, 5'd7, 32'h1111_1111, w_wre, w_ad, w_bsy);
      tick();
      for (int d = 0; d < 2; d++) begin
         wb_valid[d] = 1'b1; wb_addr[d] = 5'd7; wb_data[d] = 32'hA5A5_A5A5;
         rd_req_valid[d] = 1'b1; rs1_addr[d] = 5'd7; rs2_addr[d] = 5'd0;
         wb_cyc[d] = -1; rd_cyc[d] = -1; op1[d] = '0;
      end
      #1;
      for (int c = 0; c < 15; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (wb_valid[d] && wb_ready[d]) wb_cyc[d] = c;
            if (rd_req_valid[d] && rd_req_ready[d]) rd_cyc[d] = c;
         end
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (wb_cyc[d] == c) wb_valid[d] = 1'b0;
            if (rd_cyc[d] == c) rd_req_valid[d] = 1'b0;
            if (op_valid[d]) op1[d] = rs1_data[d];
         end
         #1;
      end
      checks++;
      if (wb_cyc[0] !== 0 || rd_cyc[0] !== 2)
         $display("FAIL prio1_order: got wb@%0d rd@%0d, required wb@0 rd@2", wb_cyc[0], rd_cyc[0]);
      else passed++;
      checks++;
      if (op1[0] !== 32'hA5A5_A5A5)
         $display("FAIL prio1_data: got %h, required a5a5a5a5", op1[0]);
      else passed++;
      checks++;
      if (rd_cyc[1] !== 0 || wb_cyc[1] !== 5)
         $display("FAIL prio0_order: got rd@%0d wb@%0d, required rd@0 wb@5", rd_cyc[1], wb_cyc[1]);
      else passed++;
      checks++;
      if (op1[1] !== 32'h1111_1111)
         $display("FAIL prio0_data: got %h, required 11111111", op1[1]);
      else passed++;
      @(posedge clk);
      #1;
      do_read(1, 5'd7, 5'd0, lat, d1, d2);
      checks++;
      if (d1 !== 32'hA5A5_A5A5 || d2 !== 32'h0)
         $display("FAIL prio0_after: got rs1=%h rs2=%h, required a5a5a5a5/00000000", d1, d2);
      else passed++;
      tick();
   endtask

   task automatic test_reset_midread();
      int n;
      int seen;
      n = 0;
      rd_req_valid[0] = 1'b1; rs1_addr[0] = 5'd5; rs2_addr[0] = 5'd5;
      #1;
      while (!rd_req_ready[0] && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      @(posedge clk);
      #1;
      rd_req_valid[0] = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (busy[0] !== 1'b0 || op_valid[0] !== 1'b0 || rs1_data[0] !== 32'h0 || rs2_data[0] !== 32'h0)
         $display("FAIL midread_reset: got busy=%b op=%b rs1=%h rs2=%h, required all 0",
                  busy[0], op_valid[0], rs1_data[0], rs2_data[0]);
      else passed++;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (op_valid[0]) seen++;
      end
      checks++;
      if (seen !== 0) $display("FAIL midread_no_op: got %0d op_valid pulses, required 0", seen);
      else passed++;
      do_read(0, 5'd5, 5'd5, lat, d1, d2);
      checks++;
      if (lat !== 4 || d1 !== 32'hDEAD_BEEF || d2 !== 32'hDEAD_BEEF)
         $display("FAIL midread_fresh: got lat=%0d rs1=%h rs2=%h, required 4/deadbeef/deadbeef", lat, d1, d2);
      else passed++;
      tick();
   endtask

   task automatic test_back_to_back();
      int          hs  [3];
      int          opc [3];
      logic [31:0] r1  [3];
      logic [31:0] r2  [3];
      int          nhs;
      int          nop;
      do_write(0, 5'd1, 32'd1, w_wre, w_ad, w_bsy);
      do_write(0, 5'd2, 32'd2, w_wre, w_ad, w_bsy);
      tick();
      nhs = 0; nop = 0;
      rd_req_valid[0] = 1'b1; rs1_addr[0] = 5'd1; rs2_addr[0] = 5'd2;
      #1;
      for (int c = 0; c < 25; c++) begin
         if (rd_req_valid[0] && rd_req_ready[0] && nhs < 3) begin
            hs[nhs] = c;
            nhs++;
         end
         @(posedge clk);
         #1;
         if (nhs == 3) rd_req_valid[0] = 1'b0;
         if (op_valid[0] && nop < 3) begin
            opc[nop] = c + 1; r1[nop] = rs1_data[0]; r2[nop] = rs2_data[0];
            nop++;
         end
         #1;
      end
      checks++;
      if (nhs !== 3 || nop !== 3)
         $display("FAIL b2b_count: got %0d handshakes %0d ops, required 3/3", nhs, nop);
      else begin
         passed++;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (hs[k] !== 5 * k || opc[k] !== 5 * k + 4)
               $display("FAIL b2b_timing%0d: got hs@%0d op@%0d, required hs@%0d op@%0d",
                        k, hs[k], opc[k], 5 * k, 5 * k + 4);
            else passed++;
            checks++;
            if (r1[k] !== 32'd1 || r2[k] !== 32'd2)
               $display("FAIL b2b_data%0d: got rs1=%h rs2=%h, required 00000001/00000002", k, r1[k], r2[k]);
            else passed++;
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_x0();
      test_priority();
      test_reset_midread();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Sequencer in front of the 32x32 single-port block-RAM register file.
- The RAM has one port, so the block serialises the two operand reads (rs1, rs2) and the writeback onto it.
- Returns both operands to decode/execute as one registered bundle.
- Hardwires x0 to zero.

Parameters:
- DATA_W, 32, register width; must equal the RAM data width.
- ADDR_W, 5, register index width; must equal the RAM address width.
- WB_PRIORITY, 1, arbitration in IDLE when both requests are valid: 1 = writeback wins, 0 = operand read wins.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req_valid  in  1  operand read request.
- rd_req_ready  out  1  block accepts the read request this cycle.
- rs1_addr  in  ADDR_W  first operand index, sampled on the read handshake.
- rs2_addr  in  ADDR_W  second operand index, sampled on the read handshake.
- op_valid  out  1  one-cycle pulse; rs1_data and rs2_data are valid.
- rs1_data  out  DATA_W  first operand, held until the next op_valid.
- rs2_data  out  DATA_W  second operand, held until the next op_valid.
- wb_valid  in  1  writeback request.
- wb_ready  out  1  block accepts the writeback this cycle.
- wb_addr  in  ADDR_W  destination index, sampled on the writeback handshake.
- wb_data  in  DATA_W  write data, sampled on the writeback handshake.
- busy  out  1  high whenever state is not IDLE.
- ram_ce  out  1  RAM clock enable.
- ram_oce  out  1  RAM output clock enable; tied to 1.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; valid the cycle after its address is presented with ce=1 and wre=0.
- ram_reset  out  1  driven directly from reset.

Behaviour:
- State machine states: IDLE, RD1, RD2, CAP, DONE, WB.
- Reset (synchronous):
  - State goes to IDLE; any in-flight read or write is abandoned and produces no op_valid.
  - op_valid=0, rs1_data=0, rs2_data=0, busy=0.
  - ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
- Ready signals (combinational from state and inputs, low during reset):
  - rd_req_ready = IDLE and not (wb_valid and WB_PRIORITY=1).
  - wb_ready = IDLE and not (rd_req_valid and WB_PRIORITY=0).
- Read handshake in IDLE: latch rs1_addr/rs2_addr, go to RD1.
- Read sequence, with T = handshake cycle:
  - RD1 (T+1): ram_ad=rs1_q, ram_ce=1, ram_wre=0.
  - RD2 (T+2): ram_ad=rs2_q, ram_ce=1; capture ram_dout into rs1_data, or 0 if rs1_q==0.
  - CAP (T+3): ram_ce=0; capture ram_dout into rs2_data, or 0 if rs2_q==0.
  - DONE (T+4): op_valid=1 for exactly one cycle, then IDLE.
  - Fixed latency: 4 cycles from handshake to op_valid; no stall input.
- Writeback handshake in IDLE: latch wb_addr and wb_data.
  - wb_addr != 0: go to WB.
  - wb_addr == 0: handshake completes, nothing is written, stay in IDLE.
- WB: ram_ad=wb_addr_q, ram_din=wb_data_q, ram_ce=1, ram_wre=1 for one cycle, then IDLE. Writeback throughput is one per 2 cycles.
- Outside RD1/RD2/WB, ram_ce=0 and ram_wre=0. ram_ad and ram_din hold their last values.
- Ordering: requests are served strictly in handshake order.
  - A write accepted before a read is visible to that read.
  - No internal bypass; a write to a register being read later returns the new value.
- op_valid never overlaps busy=0 except on its own DONE cycle (busy=1 in DONE).
- rs1_data and rs2_data change only on the RD2 and CAP captures.

Test Plan:
1. Reset 3 cycles, hold wb_valid=rd_req_valid=0 -> all outputs 0, busy=0, rd_req_ready=1, wb_ready=1.
2. Write x5=0xDEADBEEF, then read rs1=5, rs2=0 -> WB cycle shows ram_wre=1, ram_ad=5. op_valid arrives 4 cycles after the read handshake with rs1_data=0xDEADBEEF, rs2_data=0.
3. Write x0=0x12345678, then read rs1=0, rs2=0 -> ram_wre never asserts; both operands read as 0.
4. wb_valid and rd_req_valid both high in IDLE:
   - WB_PRIORITY=1: write of x7=0xA5A5A5A5 is served first, then the read of rs1=7 returns 0xA5A5A5A5.
   - WB_PRIORITY=0: the read returns the old x7 value and the write follows.
5. Pulse reset during RD2 of a read -> no op_valid; next cycle state is IDLE with rs1_data=rs2_data=0; a fresh read then completes normally.
6. Back-to-back read requests held valid, with x1=1 and x2=2 preloaded -> a handshake every 5 cycles; each op_valid shows rs1_data=1, rs2_data=2 with no gaps in sequencing.
